cube_result_stream: RTL and testbench

// - Downstream of elu_layer: captures each full activation frame (32*12 elements)
//   on the elu valid pulse.
// - Holds up to two frames in a ping-pong store.
// - Streams each frame out as 32 beats of 12 elements, with a valid/ready

---
 rtl/cube_result_stream_pkg.sv | 22 ++
 rtl/cube_result_stream_beat_select.sv | 14 +
 rtl/cube_result_stream.sv | 90 +++++++++
 tb/tb_cube_result_stream.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cube_result_stream_pkg.sv
// Frame geometry, storage types and read-FSM states shared by the result stream.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cube_result_stream_pkg;

    localparam int DATA_LEN   = 16;
    localparam int BEAT_ELEMS = 12;
    localparam int NUM_BEATS  = 32;
    localparam int BEAT_W     = BEAT_ELEMS * DATA_LEN;
    localparam int FRAME_W    = NUM_BEATS * BEAT_W;
    localparam int BEAT_IDX_W = $clog2(NUM_BEATS);

    typedef logic [BEAT_W-1:0]     beat_t;
    typedef logic [FRAME_W-1:0]    frame_t;
    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

endpackage

// File: rtl/cube_result_stream_beat_select.sv
// Slices one beat out of a full frame by beat index, beat 0 in the LSBs.
// Latency: combinational.
// Backpressure: none; a pure function of its inputs.
module cube_beat_select
    import cube_result_stream_pkg::*;
(
    input  frame_t    frame,
    input  beat_idx_t idx,
    output beat_t     beat
);

    assign beat = frame[idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/cube_result_stream.sv
// Two-slot ping-pong frame store that replays each captured frame as 32 beats.
// Latency: frame loaded at edge t is presented (beat 0, q_valid=1) right after edge t.
// Backpressure: q_ready stalls the beat counter; a load while full is dropped and sets overflow.
module cube_result_stream
    import cube_result_stream_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [FRAME_W-1:0]  d,
    output logic [BEAT_W-1:0]   q,
    output logic                q_valid,
    input  logic                q_ready,
    output logic                q_last,
    output logic                full,
    output logic                overflow
);

    frame_t    slot0;
    frame_t    slot1;
    frame_t    rd_frame;
    beat_t     sel_beat;
    beat_idx_t beat;
    logic [1:0] count;
    logic      wr_ptr;
    logic      rd_ptr;
    rd_state_t rd_state;
    logic      xfer;
    logic      fin;
    logic      accept;

    // The FSM state mirrors count!=0, so it directly provides the valid flag.
    assign q_valid = (rd_state == RD_STREAM);
    assign q_last  = q_valid && (beat == beat_idx_t'(NUM_BEATS-1));
    assign full    = (count == 2'd2);
    assign xfer    = q_valid && q_ready;
    assign fin     = xfer && q_last;
    // A full store can still take a frame when the final beat frees a slot this cycle.
    assign accept  = load && (!full || fin);

    assign rd_frame = rd_ptr ? slot1 : slot0;

    cube_beat_select u_beat_select (
        .frame (rd_frame),
        .idx   (beat),
        .beat  (sel_beat)
    );

    assign q = q_valid ? sel_beat : '0;

    // Slot storage: written whole on an accepted load, deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr_ptr) slot1 <= d;
            else        slot0 <= d;
        end
    end

    // Pointers, occupancy, beat position, sticky overflow and the read FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            beat     <= '0;
            overflow <= 1'b0;
            rd_state <= RD_IDLE;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (fin)    rd_ptr <= ~rd_ptr;

            if (xfer) beat <= fin ? '0 : beat + beat_idx_t'(1);

            case ({accept, fin})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (load && !accept) overflow <= 1'b1;

            case (rd_state)
                RD_IDLE:   if (accept) rd_state <= RD_STREAM;
                RD_STREAM: if (fin && !accept && count == 2'd1) rd_state <= RD_IDLE;
                default:   rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cube_result_stream.sv
// Directed bench for the ping-pong result stream: capture, replay, stalls, overflow, reset.
// Latency: checks beat 0 is presented the cycle after the load pulse.
// Backpressure: drives q_ready patterns and expects held beats while stalled.
module tb_cube_result_stream;
    import cube_result_stream_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               load;
    logic [FRAME_W-1:0] d;
    logic [BEAT_W-1:0]  q;
    logic               q_valid;
    logic               q_ready;
    logic               q_last;
    logic               full;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    cube_result_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .d        (d),
        .q        (q),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q_last   (q_last),
        .full     (full),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BEAT_W-1:0] obs, input logic [BEAT_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Frame whose element i holds base+i.
    function automatic logic [FRAME_W-1:0] mk_frame(input int base);
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_BEATS*BEAT_ELEMS; i++)
            f[i*DATA_LEN +: DATA_LEN] = DATA_LEN'(base + i);
        return f;
    endfunction

    // Expected beat k of that frame: elements base+12k .. base+12k+11.
    function automatic logic [BEAT_W-1:0] exp_beat(input int base, input int k);
        logic [BEAT_W-1:0] b;
        b = '0;
        for (int j = 0; j < BEAT_ELEMS; j++)
            b[j*DATA_LEN +: DATA_LEN] = DATA_LEN'(base + k*BEAT_ELEMS + j);
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One-cycle load pulse issued at a negedge; returns on the following negedge.
    task automatic pulse_load(input int base);
        load = 1'b1;
        d    = mk_frame(base);
        @(negedge clk);
        load = 1'b0;
    endtask

    // Consume one full frame. mode 0: ready held 1, valid required every cycle.
    // mode 1: ready follows a 1,0,0,1 pattern. Bounded by a cycle budget.
    task automatic drain(input int base, input int mode, input string tag);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < NUM_BEATS && cyc < 400) begin
            if (mode == 0) q_ready = 1'b1;
            else           q_ready = (cyc % 4 == 0 || cyc % 4 == 3);
            if (mode == 0) chk({tag, "_vld"}, q_valid, 1);
            if (q_valid) begin
                chk($sformatf("%s_q%0d", tag, k), q, exp_beat(base, k));
                chk($sformatf("%s_last%0d", tag, k), q_last, (k == NUM_BEATS-1));
                if (q_ready) k++;
            end
            cyc++;
            @(negedge clk);
        end
        if (k < NUM_BEATS) chk({tag, "_timeout"}, k, NUM_BEATS);
        q_ready = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        d       = '0;
        q_ready = 1'b0;
        #12;
        @(negedge clk);
        chk("rst_vld",  q_valid,  0);
        chk("rst_q",    q,        0);
        chk("rst_last", q_last,   0);
        chk("rst_full", full,     0);
        chk("rst_ovf",  overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame, ready tied high.
        q_ready = 1'b1;
        pulse_load(0);
        chk("single_first_vld", q_valid, 1);
        drain(0, 0, "single");
        chk("single_after_vld", q_valid, 0);
        chk("single_after_q", q, 0);

        // Backpressure pattern.
        pulse_load(500);
        drain(500, 1, "bp");
        chk("bp_after_vld", q_valid, 0);

        // Two frames back-to-back, streamed without a bubble.
        pulse_load(1000);
        @(negedge clk);
        pulse_load(2000);
        chk("two_full", full, 1);
        drain(1000, 0, "twoA");
        drain(2000, 0, "twoB");
        chk("two_after_vld", q_valid, 0);
        chk("two_after_full", full, 0);

        // Overflow: third frame dropped while full and stalled.
        pulse_load(1000);
        pulse_load(2000);
        chk("ovf_pre", overflow, 0);
        pulse_load(3000);
        chk("ovf_set", overflow, 1);
        chk("ovf_full", full, 1);
        drain(1000, 0, "ovfA");
        drain(2000, 0, "ovfB");
        chk("ovf_noC_vld", q_valid, 0);
        chk("ovf_sticky", overflow, 1);
        do_reset();
        chk("ovf_cleared", overflow, 0);

        // Load coinciding with the final-beat handshake while full.
        pulse_load(1000);
        pulse_load(2000);
        for (int k = 0; k < NUM_BEATS; k++) begin
            q_ready = 1'b1;
            if (k == NUM_BEATS-1) begin
                load = 1'b1;
                d    = mk_frame(3000);
            end
            chk($sformatf("edgeA_q%0d", k), q, exp_beat(1000, k));
            @(negedge clk);
            load = 1'b0;
        end
        chk("edge_ovf", overflow, 0);
        chk("edge_full", full, 1);
        drain(2000, 0, "edgeB");
        drain(3000, 0, "edgeC");
        chk("edge_after_vld", q_valid, 0);

        // Reset mid-stream at beat 10 of A, with B stored and overflow set.
        q_ready = 1'b0;
        pulse_load(1000);
        pulse_load(2000);
        pulse_load(3000);
        chk("mid_pre_ovf", overflow, 1);
        for (int k = 0; k < 10; k++) begin
            q_ready = 1'b1;
            @(negedge clk);
        end
        q_ready = 1'b0;
        chk("mid_beat10", q, exp_beat(1000, 10));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld",  q_valid,  0);
        chk("mid_rst_q",    q,        0);
        chk("mid_rst_full", full,     0);
        chk("mid_rst_ovf",  overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_idle_vld", q_valid, 0);
        pulse_load(4000);
        drain(4000, 0, "midD");
        chk("mid_after_vld", q_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
